countdown_ctrl: RTL
===================

Name: countdown_ctrl

Overview:
- Central sequencer for the countdown timer: consumes the single-cycle, already-debounced key pulses and owns the mm:ss BCD time registers, the 1 Hz tick prescaler, the run/pause/done state machine and the alarm output.
- Sits between the button debounce stage and the display/buzzer logic.
- Purely synchronous to clk; all inputs are treated as clean one-cycle pulses.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per countdown second (10 MHz → 1 s); must be ≥ 2.
- ALARM_TICKS, 5, number of seconds the alarm stays asserted in DONE before auto-return to IDLE; must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- key_pulse  input  4  one-cycle key pulses: [0]=start/pause, [1]=clear, [2]=minute+, [3]=second+.
- min_bcd  output  8  minutes, two BCD digits 00..59 ([7:4] tens, [3:0] units).
- sec_bcd  output  8  seconds, two BCD digits 00..59.
- state  output  2  00=IDLE, 01=RUN, 10=PAUSE, 11=DONE.
- running  output  1  high only in RUN.
- alarm  output  1  high only in DONE.

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-count included):
  - state=IDLE, min_bcd=00, sec_bcd=00, running=0, alarm=0.
  - Prescaler and alarm counter cleared; pulses in the same cycle are ignored.
- All outputs are registered. A key pulse at edge n is reflected on the outputs after edge n+1 (1-cycle latency).
- Key priority when several bits are high in one cycle: clear > start/pause > minute+ > second+. Only the highest-priority bit is acted on; the rest are discarded.
- BCD arithmetic:
  - Each field is always a valid BCD value in 00..59.
  - Increment: units 9 → 0 with tens +1; 59 → 00 wraps and does not carry into minutes.
  - Decrement: units 0 → 9 with tens −1.
- Prescaler:
  - Counts 0..TICK_DIV−1, counting only in RUN; tick is asserted when the count equals TICK_DIV−1, and the count then returns to 0.
  - Held, not cleared, in PAUSE.
  - Cleared on entry to RUN from IDLE and on any entry to IDLE.
- IDLE:
  - minute+ increments min_bcd; second+ increments sec_bcd.
  - start: if time ≠ 00:00, go to RUN; if time = 00:00, ignore.
  - clear: time := 00:00, stay in IDLE.
- RUN:
  - On tick: if sec=00, then sec:=59 and min:=min−1; otherwise sec:=sec−1.
  - If the result is 00:00, go to DONE on the same edge and clear the alarm counter.
  - start: go to PAUSE. A tick in the same cycle is applied first; if that decrement reaches 00:00, DONE wins over PAUSE.
  - clear: time := 00:00, go to IDLE; a coincident tick is discarded.
  - minute+ and second+ are ignored.
- PAUSE:
  - Time and prescaler are frozen.
  - start: go to RUN, with the prescaler resuming from its held value.
  - clear: time := 00:00, go to IDLE.
  - minute+ and second+ are ignored.
- DONE:
  - alarm=1 and time stays 00:00; the prescaler keeps running and the alarm counter increments on each tick.
  - The alarm counter reaching ALARM_TICKS sends the state to IDLE.
  - Any key pulse sends the state to IDLE immediately; the pulse's own function is not executed.
- running and alarm are direct decodes of the registered state; no glitches are permitted.

Test Plan:
- Reset/preset (TICK_DIV=4, ALARM_TICKS=3): rst mid-RUN → next cycle state=00, min/sec=00, running=0, alarm=0. Then minute+ ×2 and second+ ×10 → min_bcd=0x02, sec_bcd=0x10. start at 00:00 → state remains IDLE.
- BCD wrap: second+ ×60 from 00 → sec_bcd=0x00, min_bcd unchanged. minute+ ×59 → 0x59; one more → 0x00.
- Borrow: preset 01:00, start → after 4 cycles sec=0x59, min=0x00. Continue to 00:00 → state=DONE and alarm=1 on the same edge as the final decrement.
- Pause/resume: preset 00:05, start, wait 6 cycles (prescaler=2 held), start → state=PAUSE, time frozen for 20 cycles. start → first tick 1 cycle later (prescaler resumes at 2→3).
- Simultaneous events: key_pulse=4'b0011 in RUN → IDLE with time 00:00. Start coincident with a tick taking 00:01→00:00 → DONE, not PAUSE. Second+ with minute+ in IDLE → only minutes increment.
- Alarm exit: DONE with no keys → alarm high for exactly 3×4=12 cycles, then IDLE. Re-enter DONE and pulse second+ → IDLE next cycle with sec_bcd still 0x00.

Source files
------------

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: central sequencer for the mm:ss countdown timer.
// It decodes the debounced key pulses, holds the BCD time registers, runs
// the 1 Hz prescaler and the IDLE/RUN/PAUSE/DONE state machine, and drives
// the alarm. Every output is a register, so there is one cycle of latency
// from a key pulse to the outputs.
module countdown_ctrl #(
    parameter int TICK_DIV    = 10_000_000,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_pulse,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACNT_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_min;
    logic [7:0]    r_sec;
    logic [7:0]    w_min_nxt;
    logic [7:0]    w_sec_nxt;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [AW-1:0] r_acnt;
    logic [AW-1:0] w_acnt_nxt;
    logic          r_running;
    logic          r_alarm;

    logic          w_clr;
    logic          w_start;
    logic          w_minp;
    logic          w_secp;
    logic          w_tick;
    logic          w_time_zero;
    logic          w_last_sec;
    logic [7:0]    w_min_dec;
    logic [7:0]    w_sec_dec;

    // BCD increment within 00..59; 59 wraps to 00 with no carry out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement; only ever applied to a non-zero value.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Key priority: clear > start/pause > minute+ > second+.
    assign w_clr   = key_pulse[1];
    assign w_start = key_pulse[0] & ~key_pulse[1];
    assign w_minp  = key_pulse[2] & ~key_pulse[1] & ~key_pulse[0];
    assign w_secp  = key_pulse[3] & ~key_pulse[2] & ~key_pulse[1] & ~key_pulse[0];

    // The prescaler only sits at its top value while counting, so no state gate is needed.
    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_time_zero = (r_min == 8'h00) && (r_sec == 8'h00);
    assign w_last_sec  = (r_min == 8'h00) && (r_sec == 8'h01);
    assign w_sec_dec   = (r_sec == 8'h00) ? 8'h59 : bcd_dec(r_sec);
    assign w_min_dec   = (r_sec == 8'h00) ? bcd_dec(r_min) : r_min;

    // Next-state, time, prescaler and alarm-counter decision for this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        w_acnt_nxt  = r_acnt;
        case (r_state)
            S_IDLE: begin
                if (w_clr) begin
                    w_min_nxt = 8'h00;
                    w_sec_nxt = 8'h00;
                end else if (w_start) begin
                    if (!w_time_zero) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end else if (w_minp) begin
                    w_min_nxt = bcd_inc(r_min);
                end else if (w_secp) begin
                    w_sec_nxt = bcd_inc(r_sec);
                end
            end
            S_RUN: begin
                if (w_clr) begin
                    w_min_nxt   = 8'h00;
                    w_sec_nxt   = 8'h00;
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    // The tick lands before a coincident pause; reaching 00:00 beats PAUSE.
                    w_presc_nxt = '0;
                    w_min_nxt   = w_min_dec;
                    w_sec_nxt   = w_sec_dec;
                    if (w_last_sec) begin
                        w_state_nxt = S_DONE;
                        w_acnt_nxt  = '0;
                    end else if (w_start) begin
                        w_state_nxt = S_PAUSE;
                    end
                end else if (w_start) begin
                    // The pausing edge leaves the count alone and the resuming edge
                    // advances it, so a pause/resume pair keeps the tick phase exact.
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (w_clr) begin
                    w_min_nxt   = 8'h00;
                    w_sec_nxt   = 8'h00;
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                end else if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            S_DONE: begin
                if (|key_pulse) begin
                    w_state_nxt = S_IDLE;
                    w_presc_nxt = '0;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_acnt == ACNT_LAST)
                        w_state_nxt = S_IDLE;
                    else
                        w_acnt_nxt = r_acnt + AW'(1);
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; running/alarm are registered decodes of the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_min     <= 8'h00;
            r_sec     <= 8'h00;
            r_presc   <= '0;
            r_acnt    <= '0;
            r_running <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min     <= w_min_nxt;
            r_sec     <= w_sec_nxt;
            r_presc   <= w_presc_nxt;
            r_acnt    <= w_acnt_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_alarm   <= (w_state_nxt == S_DONE);
        end
    end

    assign min_bcd = r_min;
    assign sec_bcd = r_sec;
    assign state   = r_state;
    assign running = r_running;
    assign alarm   = r_alarm;

endmodule
